// File: rtl/phoenix_dl_pkg.sv
// Shared types and default ROM map for the Phoenix download controller.
package phoenix_dl_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, READY} dl_state_t;

    typedef logic [1:0] dl_region_t;

    localparam dl_region_t REG_PROG = 2'd0;
    localparam dl_region_t REG_FG   = 2'd1;
    localparam dl_region_t REG_BG   = 2'd2;
    localparam dl_region_t REG_PROM = 2'd3;

    localparam logic [7:0]  DEF_DL_INDEX    = 8'h00;
    localparam logic [15:0] DEF_FG_BASE     = 16'h4000;
    localparam logic [15:0] DEF_BG_BASE     = 16'h5000;
    localparam logic [15:0] DEF_PROM_BASE   = 16'h6000;
    localparam logic [15:0] DEF_MAX_BYTES   = 16'h6200;
    localparam int          DEF_HOLD_CYCLES = 16;

endpackage

// File: rtl/phoenix_dl_region_dec.sv
// Combinational ROM-map decode: byte address to region tag.
module phoenix_dl_region_dec
    import phoenix_dl_pkg::*;
#(
    parameter logic [15:0] FG_BASE   = DEF_FG_BASE,
    parameter logic [15:0] BG_BASE   = DEF_BG_BASE,
    parameter logic [15:0] PROM_BASE = DEF_PROM_BASE
) (
    input  logic [15:0] addr,
    output logic [1:0]  region
);

    always_comb begin
        if (addr < FG_BASE)        region = REG_PROG;
        else if (addr < BG_BASE)   region = REG_FG;
        else if (addr < PROM_BASE) region = REG_BG;
        else                       region = REG_PROM;
    end

endmodule

// File: rtl/phoenix_dl_ctrl.sv
// ROM download qualifier/re-timer and core reset sequencer for Phoenix.
// Optional checksum on dl_sum is built when DL_CHECKSUM_EN is defined.
//   state | meaning
//   IDLE  | no download seen yet, core held in reset
//   LOAD  | download running, accepting writes
//   HOLD  | download finished, settle timer running
//   READY | ROM loaded, core reset follows user_reset
module phoenix_dl_ctrl
    import phoenix_dl_pkg::*;
#(
    parameter logic [7:0]  DL_INDEX    = DEF_DL_INDEX,
    parameter logic [15:0] FG_BASE     = DEF_FG_BASE,
    parameter logic [15:0] BG_BASE     = DEF_BG_BASE,
    parameter logic [15:0] PROM_BASE   = DEF_PROM_BASE,
    parameter logic [15:0] MAX_BYTES   = DEF_MAX_BYTES,
    parameter int          HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        user_reset,
    input  logic        ioctl_downl,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic [1:0]  dl_region,
    output logic [15:0] dl_bytes,
    output logic        dl_overflow,
    output logic        dl_done,
    output logic [15:0] dl_sum,
    output logic        core_reset
);

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    dl_state_t   state, next_state;
    logic        start;
    logic [15:0] hold_cnt;
    logic [1:0]  region;
    logic        qual_dl, in_range, acc, oor;

    // Full 25-bit compare so anything past 64 KiB is out of range.
    assign qual_dl  = ioctl_downl && (ioctl_index == DL_INDEX);
    assign in_range = ioctl_addr < {9'd0, MAX_BYTES};
    assign acc      = ioctl_wr && qual_dl && in_range;
    assign oor      = ioctl_wr && qual_dl && !in_range;

    phoenix_dl_region_dec #(
        .FG_BASE   (FG_BASE),
        .BG_BASE   (BG_BASE),
        .PROM_BASE (PROM_BASE)
    ) u_region_dec (
        .addr   (ioctl_addr[15:0]),
        .region (region)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (qual_dl) begin
                    next_state = LOAD;
                    start      = 1'b1;
                end
            end
            LOAD: begin
                if (!ioctl_downl) next_state = HOLD;
            end
            HOLD: begin
                if (qual_dl) begin
                    next_state = LOAD;
                    start      = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    next_state = READY;
                end
            end
            READY: begin
                if (qual_dl) begin
                    next_state = LOAD;
                    start      = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign dl_done = (state == READY);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_wr       <= 1'b0;
            dl_addr     <= 16'h0000;
            dl_data     <= 8'h00;
            dl_region   <= REG_PROG;
            dl_bytes    <= 16'h0000;
            dl_overflow <= 1'b0;
            hold_cnt    <= 16'h0000;
            core_reset  <= 1'b1;
        end else begin
            dl_wr <= acc;
            if (acc) begin
                dl_addr   <= ioctl_addr[15:0];
                dl_data   <= ioctl_dout;
                dl_region <= region;
            end
            // A strobe coinciding with the download start is the first byte.
            if (start)                            dl_bytes <= acc ? 16'd1 : 16'd0;
            else if (acc && dl_bytes != 16'hFFFF) dl_bytes <= dl_bytes + 16'd1;
            if (start)    dl_overflow <= oor;
            else if (oor) dl_overflow <= 1'b1;
            hold_cnt   <= (state == HOLD) ? hold_cnt + 16'd1 : 16'h0000;
            core_reset <= (next_state == READY) ? user_reset : 1'b1;
        end
    end

`ifdef DL_CHECKSUM_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)      dl_sum <= 16'h0000;
        else if (start) dl_sum <= acc ? {8'h00, ioctl_dout} : 16'h0000;
        else if (acc)   dl_sum <= dl_sum + {8'h00, ioctl_dout};
    end
`else
    assign dl_sum = 16'h0000;
`endif

endmodule
